falafel_lsu_arbiter: RTL
========================

Name: falafel_lsu_arbiter

Overview:
- Shares the single falafel LSU request/response channel between NUM_REQ requester units, e.g. allocator FSM, free/coalesce FSM and debug port.
- Grants one requester at a time, round-robin.
- Holds the grant from request handshake until the matching LSU response is consumed.
- Sits between the requesters and the LSU's alloc_req/alloc_rsp ports. The LSU is untouched.

Parameters:
- NUM_REQ, 2: number of requesters. Legal range 2..8.
- IDX_W, $clog2(NUM_REQ): grant index width. Derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_val_i  in  [NUM_REQ]  per-requester request valid
- req_rdy_o  out  [NUM_REQ]  per-requester request ready
- req_op_i  in  [NUM_REQ] x lsu_op_e  per-requester op
- req_addr_i  in  [NUM_REQ] x word_t  per-requester address
- req_word_i  in  [NUM_REQ] x word_t  per-requester store word
- req_block_i  in  [NUM_REQ] x free_block_t  per-requester store block
- rsp_val_o  out  [NUM_REQ]  per-requester response valid
- rsp_rdy_i  in  [NUM_REQ]  per-requester response ready
- rsp_word_o  out  word_t  response word, broadcast to all requesters
- rsp_block_o  out  free_block_t  response block, broadcast to all requesters
- lsu_req_val_o  out  1  to LSU alloc_req_val_i
- lsu_req_rdy_i  in  1  from LSU alloc_req_rdy_o
- lsu_req_op_o  out  lsu_op_e  to LSU
- lsu_req_addr_o  out  word_t  to LSU
- lsu_req_word_o  out  word_t  to LSU
- lsu_req_block_o  out  free_block_t  to LSU
- lsu_rsp_val_i  in  1  from LSU alloc_rsp_val_o
- lsu_rsp_rdy_o  out  1  to LSU alloc_rsp_rdy_i
- lsu_rsp_word_i  in  word_t  from LSU
- lsu_rsp_block_i  in  free_block_t  from LSU
- busy_o  out  1  grant held (state != ARB_IDLE)
- grant_idx_o  out  IDX_W  current or last grant index

Behaviour:
- Reset (rst_i high at posedge):
  - state_q = ARB_IDLE, rr_ptr_q = 0, grant_q = 0.
  - All rdy/val outputs and busy_o are 0. Payload outputs are 0 while not forwarding.
  - Reset mid-transaction abandons it with no response. The LSU must be reset in the same cycle.
- ARB_IDLE:
  - Winner = first i with req_val_i[i], scanning from rr_ptr_q upward, modulo NUM_REQ.
  - If any valid: grant_q <= winner, go to ARB_FWD. No handshake happens in ARB_IDLE; all req_rdy_o = 0.
- ARB_FWD:
  - lsu_req_* = req_*[grant_q], lsu_req_val_o = req_val_i[grant_q].
  - req_rdy_o[grant_q] = lsu_req_rdy_i; all other req_rdy_o = 0.
  - On lsu_req_val_o && lsu_req_rdy_i: go to ARB_WAIT_RSP.
- ARB_WAIT_RSP:
  - rsp_val_o[grant_q] = lsu_rsp_val_i; lsu_rsp_rdy_o = rsp_rdy_i[grant_q]. Other rsp_val_o = 0.
  - rsp_word_o/rsp_block_o pass through from the LSU at all times.
  - On response handshake: rr_ptr_q <= (grant_q + 1) mod NUM_REQ, go to ARB_IDLE.
- Latency: one arbitration cycle (ARB_IDLE→ARB_FWD) plus LSU latency.
- Minimum gap between transactions: one idle cycle.
- Fairness: a continuously requesting unit waits at most NUM_REQ-1 transactions.
- Wrap-around: rr_ptr_q wraps NUM_REQ-1→0. For non-power-of-2 NUM_REQ, the index must never reach NUM_REQ.
- Requester rule: valid/ready protocol. Once req_val_i is high, it and its payload stay stable until req_rdy_o. A requester dropping valid while in ARB_FWD is a protocol error, covered by a simulation assertion. The RTL then stays in ARB_FWD.
- Simultaneous events: a new req_val_i arriving during ARB_WAIT_RSP only gets rdy after return to ARB_IDLE.
- busy_o = (state_q != ARB_IDLE); grant_idx_o = grant_q.

Decomposition:
- lsu_op_e, word_t, free_block_t, WORD_SIZE: existing falafel_pkg.
- Add arb_state_e (ARB_IDLE, ARB_FWD, ARB_WAIT_RSP) to falafel_pkg.
- One natural sub-module: falafel_rr_picker.
  - Combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: any_valid and winner index.
  - Reusable by future block-list arbitration.

Test Plan:
- Single requester, NUM_REQ=2: req0 LOAD_WORD addr 0x100, LSU mock returns 0xDEADBEEF. Required:
  - rsp_val_o=2'b01, rsp_word_o=0xDEADBEEF.
  - req_rdy_o[1] stays 0 throughout.
  - rr_ptr then = 1.
- Contention: req0 and req1 both valid from reset. Required:
  - Grant order 0,1,0,1 over four transactions.
  - Each grant preceded by exactly one ARB_IDLE cycle.
- Wrap, NUM_REQ=3: all three valid continuously. Required:
  - Grant order 0,1,2,0.
  - grant_idx_o never equals 3.
- Backpressure: LSU holds alloc_req_rdy low 5 cycles, then requester holds rsp_rdy low 4 cycles. Required:
  - Arbiter stays in ARB_FWD, then ARB_WAIT_RSP.
  - Payload stable; no second grant.
- STORE_BLOCK via req1: size=0x40, next_ptr=0x200, addr 0x80. Required:
  - lsu_req_block_o matches the request.
  - Response delivered only to req1.
- Reset mid ARB_WAIT_RSP: rst_i high for 1 cycle. Required:
  - busy_o=0 and all val/rdy outputs 0 the next cycle.
  - rr_ptr=0.
  - Next contention grants req0 first.

Source files
------------

// File: rtl/falafel_pkg.sv
// Shared falafel LSU types: op codes, word/free-block payloads and the
// state encoding of the LSU request arbiter.
package falafel_pkg;

  localparam int WORD_SIZE = 32;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    LSU_NOP     = 2'd0,
    LOAD_WORD   = 2'd1,
    STORE_WORD  = 2'd2,
    STORE_BLOCK = 2'd3
  } lsu_op_e;

  typedef struct packed {
    word_t size;
    word_t next_ptr;
  } free_block_t;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_FWD      = 2'd1,
    ARB_WAIT_RSP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/falafel_rr_picker.sv
// Combinational round-robin picker: first set bit of req_i at or above
// rr_ptr_i, wrapping modulo NUM_REQ.
module falafel_rr_picker
  import falafel_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Scan farthest-first so the candidate closest to rr_ptr_i is written last.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    sum      = '0;
    idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/falafel_lsu_arbiter.sv
// Round-robin arbiter sharing the falafel LSU alloc request/response channel
// between NUM_REQ requesters; the grant is held until the response is consumed.
module falafel_lsu_arbiter
  import falafel_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_val_i,
  output logic [NUM_REQ-1:0]               req_rdy_o,
  input  lsu_op_e     [NUM_REQ-1:0]        req_op_i,
  input  word_t       [NUM_REQ-1:0]        req_addr_i,
  input  word_t       [NUM_REQ-1:0]        req_word_i,
  input  free_block_t [NUM_REQ-1:0]        req_block_i,
  output logic [NUM_REQ-1:0]               rsp_val_o,
  input  logic [NUM_REQ-1:0]               rsp_rdy_i,
  output word_t                            rsp_word_o,
  output free_block_t                      rsp_block_o,
  output logic                             lsu_req_val_o,
  input  logic                             lsu_req_rdy_i,
  output lsu_op_e                          lsu_req_op_o,
  output word_t                            lsu_req_addr_o,
  output word_t                            lsu_req_word_o,
  output free_block_t                      lsu_req_block_o,
  input  logic                             lsu_rsp_val_i,
  output logic                             lsu_rsp_rdy_o,
  input  word_t                            lsu_rsp_word_i,
  input  free_block_t                      lsu_rsp_block_i,
  output logic                             busy_o,
  output logic [IDX_W-1:0]                 grant_idx_o
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic             any_val;
  logic [IDX_W-1:0] winner;

  falafel_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_i    (req_val_i),
    .rr_ptr_i (rr_ptr_q),
    .any_o    (any_val),
    .winner_o (winner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_val) begin
            grant_q <= winner;
            state_q <= ARB_FWD;
          end
        end
        ARB_FWD: begin
          if (lsu_req_val_o && lsu_req_rdy_i) state_q <= ARB_WAIT_RSP;
        end
        ARB_WAIT_RSP: begin
          if (lsu_rsp_val_i && lsu_rsp_rdy_o) begin
            rr_ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            state_q  <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Handshakes pass straight through to the granted requester only.
  always_comb begin
    req_rdy_o       = '0;
    rsp_val_o       = '0;
    lsu_req_val_o   = 1'b0;
    lsu_req_op_o    = LSU_NOP;
    lsu_req_addr_o  = '0;
    lsu_req_word_o  = '0;
    lsu_req_block_o = '0;
    lsu_rsp_rdy_o   = 1'b0;
    case (state_q)
      ARB_FWD: begin
        lsu_req_val_o      = req_val_i[grant_q];
        lsu_req_op_o       = req_op_i[grant_q];
        lsu_req_addr_o     = req_addr_i[grant_q];
        lsu_req_word_o     = req_word_i[grant_q];
        lsu_req_block_o    = req_block_i[grant_q];
        req_rdy_o[grant_q] = lsu_req_rdy_i;
      end
      ARB_WAIT_RSP: begin
        rsp_val_o[grant_q] = lsu_rsp_val_i;
        lsu_rsp_rdy_o      = rsp_rdy_i[grant_q];
      end
      default: ;
    endcase
  end

  assign rsp_word_o  = lsu_rsp_word_i;
  assign rsp_block_o = lsu_rsp_block_i;
  assign busy_o      = (state_q != ARB_IDLE);
  assign grant_idx_o = grant_q;

  // A granted requester must hold valid until its request is accepted.
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ARB_FWD) |-> req_val_i[grant_q]);

endmodule
